alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 30 +++
 rtl/alu_arbiter_if.sv | 38 +++
 rtl/alu_arbiter_alu.sv | 34 +++
 rtl/alu_arbiter.sv | 115 +++++++++++
 tb/tb_alu_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-port ALU arbiter:
// FSM states, ALU control codes, legal-code check.
package alu_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] CTL_AND  = 4'b0000;
   localparam logic [3:0] CTL_OR   = 4'b0001;
   localparam logic [3:0] CTL_ADD  = 4'b0010;
   localparam logic [3:0] CTL_SLL  = 4'b0011;
   localparam logic [3:0] CTL_SRL  = 4'b0100;
   localparam logic [3:0] CTL_SUB  = 4'b0110;
   localparam logic [3:0] CTL_SLT  = 4'b0111;
   localparam logic [3:0] CTL_SLTU = 4'b1011;

   function automatic logic ctl_legal(input logic [3:0] ctl);
      logic ok;
      case (ctl)
         CTL_AND, CTL_OR, CTL_ADD, CTL_SLL,
         CTL_SRL, CTL_SUB, CTL_SLT, CTL_SLTU: ok = 1'b1;
         default:                              ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters
// and the ALU arbiter.
interface alu_arbiter_if;

   logic [1:0]         reqValid;
   logic [1:0]         reqReady;
   logic signed [31:0] reqOpA0;
   logic signed [31:0] reqOpA1;
   logic signed [31:0] reqOpB0;
   logic signed [31:0] reqOpB1;
   logic [3:0]         reqCtl0;
   logic [3:0]         reqCtl1;
   logic [4:0]         reqShamt0;
   logic [4:0]         reqShamt1;
   logic               respValid;
   logic               respReady;
   logic               respId;
   logic [31:0]        respResult;
   logic               respZero;
   logic               respIllegal;

   modport master (
      output reqValid, reqOpA0, reqOpA1, reqOpB0, reqOpB1,
      output reqCtl0, reqCtl1, reqShamt0, reqShamt1,
      output respReady,
      input  reqReady,
      input  respValid, respId, respResult, respZero, respIllegal
   );

   modport slave (
      input  reqValid, reqOpA0, reqOpA1, reqOpB0, reqOpB1,
      input  reqCtl0, reqCtl1, reqShamt0, reqShamt1,
      input  respReady,
      output reqReady,
      output respValid, respId, respResult, respZero, respIllegal
   );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Team ALU: combinational, 32-bit, eight ops.
// Shifts act on B; zero flags A == B for every op.
module alu_arbiter_alu
   import alu_arbiter_pkg::*;
(
   input  logic signed [31:0] a,
   input  logic signed [31:0] b,
   input  logic [3:0]         ctl,
   input  logic [4:0]         shamt,
   output logic [31:0]        result,
   output logic               zero,
   output logic               illegal
);

   // Operation select; unknown codes yield zero.
   always_comb begin
      result = '0;
      case (ctl)
         CTL_AND:  result = a & b;
         CTL_OR:   result = a | b;
         CTL_ADD:  result = a + b;
         CTL_SUB:  result = a - b;
         CTL_SLT:  result = {31'd0, a < b};
         CTL_SLTU: result = {31'd0, $unsigned(a) < $unsigned(b)};
         CTL_SLL:  result = $unsigned(b) << shamt;
         CTL_SRL:  result = $unsigned(b) >> shamt;
         default:  result = '0;
      endcase
   end

   assign zero    = (a == b);
   assign illegal = !ctl_legal(ctl);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end to one shared ALU.
// Accept -> EXEC -> RESP, one op in flight at a time.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int FIXED_PRIORITY = 0
) (
   input logic          clk,
   input logic          rst_n,
   alu_arbiter_if.slave bus
);

   state_t             state;
   logic               last_grant;
   logic               win;
   logic               any_req;
   logic [1:0]         grant;

   logic signed [31:0] lat_a;
   logic signed [31:0] lat_b;
   logic [3:0]         lat_ctl;
   logic [4:0]         lat_shamt;
   logic               lat_id;

   logic [31:0]        alu_res;
   logic               alu_zero;
   logic               alu_ill;

   logic               r_valid;
   logic               r_id;
   logic [31:0]        r_result;
   logic               r_zero;
   logic               r_ill;

   assign any_req = |bus.reqValid;

   // Winner pick: fixed favours 0, else alternate on contention.
   always_comb begin
      win = 1'b0;
      if (FIXED_PRIORITY != 0)
         win = ~bus.reqValid[0];
      else if (&bus.reqValid)
         win = ~last_grant;
      else
         win = bus.reqValid[1];
   end

   assign grant = (rst_n && state == IDLE && any_req)
                ? (win ? 2'b10 : 2'b01) : 2'b00;

   assign bus.reqReady    = grant;
   assign bus.respValid   = r_valid;
   assign bus.respId      = r_id;
   assign bus.respResult  = r_result;
   assign bus.respZero    = r_zero;
   assign bus.respIllegal = r_ill;

   alu_arbiter_alu u_alu (
      .a       (lat_a),
      .b       (lat_b),
      .ctl     (lat_ctl),
      .shamt   (lat_shamt),
      .result  (alu_res),
      .zero    (alu_zero),
      .illegal (alu_ill)
   );

   // Control FSM with latched operands and registered response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         lat_a      <= '0;
         lat_b      <= '0;
         lat_ctl    <= '0;
         lat_shamt  <= '0;
         lat_id     <= 1'b0;
         r_valid    <= 1'b0;
         r_id       <= 1'b0;
         r_result   <= '0;
         r_zero     <= 1'b0;
         r_ill      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  lat_a      <= win ? bus.reqOpA1 : bus.reqOpA0;
                  lat_b      <= win ? bus.reqOpB1 : bus.reqOpB0;
                  lat_ctl    <= win ? bus.reqCtl1 : bus.reqCtl0;
                  lat_shamt  <= win ? bus.reqShamt1 : bus.reqShamt0;
                  lat_id     <= win;
                  last_grant <= win;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               r_result <= alu_res;
               r_zero   <= alu_zero;
               r_ill    <= alu_ill;
               r_id     <= lat_id;
               r_valid  <= 1'b1;
               state    <= RESP;
            end
            RESP: begin
               if (bus.respReady) begin
                  r_valid <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: round-robin and
// fixed-priority instances driven in lockstep.
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   logic clk;
   logic rst_n;
   int   compared   = 0;
   int   mismatched = 0;

   alu_arbiter_if bus ();
   alu_arbiter_if bus_fp ();

   alu_arbiter #(.FIXED_PRIORITY(0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   alu_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_fp)
   );

   assign bus_fp.reqValid  = bus.reqValid;
   assign bus_fp.reqOpA0   = bus.reqOpA0;
   assign bus_fp.reqOpA1   = bus.reqOpA1;
   assign bus_fp.reqOpB0   = bus.reqOpB0;
   assign bus_fp.reqOpB1   = bus.reqOpB1;
   assign bus_fp.reqCtl0   = bus.reqCtl0;
   assign bus_fp.reqCtl1   = bus.reqCtl1;
   assign bus_fp.reqShamt0 = bus.reqShamt0;
   assign bus_fp.reqShamt1 = bus.reqShamt1;
   assign bus_fp.respReady = bus.respReady;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic set_req(input bit id, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] c,
                          input logic [4:0] s);
      if (id) begin
         bus.reqOpA1 = a; bus.reqOpB1 = b;
         bus.reqCtl1 = c; bus.reqShamt1 = s;
      end else begin
         bus.reqOpA0 = a; bus.reqOpB0 = b;
         bus.reqCtl0 = c; bus.reqShamt0 = s;
      end
   endtask

   // Lone request on one port; inputs disturbed after accept.
   task automatic do_op(input bit id, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] c,
                        input logic [4:0] s,
                        output logic [1:0] rdy, output logic vx,
                        output logic vr, output logic rid,
                        output logic [31:0] res, output logic z,
                        output logic ill);
      @(negedge clk);
      set_req(id, a, b, c, s);
      bus.reqValid = id ? 2'b10 : 2'b01;
      #1 rdy = bus.reqReady;
      @(posedge clk); #1;
      bus.reqValid = 2'b00;
      set_req(id, ~a, ~b, c, s);
      vx = bus.respValid;
      @(posedge clk); #1;
      vr  = bus.respValid;
      rid = bus.respId;
      res = bus.respResult;
      z   = bus.respZero;
      ill = bus.respIllegal;
      bus.respReady = 1'b1;
      @(posedge clk); #1;
      bus.respReady = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.reqValid  = 2'b11;
      bus.respReady = 1'b0;
      set_req(0, 0, 0, 0, 0);
      set_req(1, 0, 0, 0, 0);
      #12;
      compared++; if (bus.reqReady !== 2'b00) begin mismatched++; $display("FAIL rst_ready got %b want 00", bus.reqReady); end
      compared++; if (bus.respValid !== 1'b0) begin mismatched++; $display("FAIL rst_valid got %b want 0", bus.respValid); end
      compared++; if (bus.respId !== 1'b0) begin mismatched++; $display("FAIL rst_id got %b want 0", bus.respId); end
      compared++; if (bus.respResult !== 32'd0) begin mismatched++; $display("FAIL rst_result got %h want 0", bus.respResult); end
      compared++; if ({bus.respZero, bus.respIllegal} !== 2'b00) begin mismatched++; $display("FAIL rst_flags got %b want 00", {bus.respZero, bus.respIllegal}); end
      bus.reqValid = 2'b00;
      rst_n = 1'b1;
   endtask

   // First edge after reset release accepts a lone add.
   task automatic test_single_add;
      set_req(0, 5, 7, CTL_ADD, 0);
      bus.reqValid = 2'b01;
      #1;
      compared++; if (bus.reqReady !== 2'b01) begin mismatched++; $display("FAIL add_ready got %b want 01", bus.reqReady); end
      @(posedge clk); #1;
      bus.reqValid = 2'b00;
      set_req(0, 50, 70, CTL_SUB, 0);
      compared++; if (bus.respValid !== 1'b0) begin mismatched++; $display("FAIL add_exec_valid got %b want 0", bus.respValid); end
      @(posedge clk); #1;
      compared++; if (bus.respValid !== 1'b1) begin mismatched++; $display("FAIL add_valid got %b want 1", bus.respValid); end
      compared++; if (bus.respId !== 1'b0) begin mismatched++; $display("FAIL add_id got %b want 0", bus.respId); end
      compared++; if (bus.respResult !== 32'd12) begin mismatched++; $display("FAIL add_result got %0d want 12", bus.respResult); end
      compared++; if (bus.respZero !== 1'b0) begin mismatched++; $display("FAIL add_zero got %b want 0", bus.respZero); end
      bus.respReady = 1'b1;
      @(posedge clk); #1;
      bus.respReady = 1'b0;
      compared++; if (bus.respValid !== 1'b0) begin mismatched++; $display("FAIL add_drop got %b want 0", bus.respValid); end
   endtask

   task automatic test_boundaries;
      logic [1:0] rdy; logic vx, vr, rid, z, ill; logic [31:0] res;
      do_op(0, 32'h7FFF_FFFF, 32'd1, CTL_ADD, 0, rdy, vx, vr, rid, res, z, ill);
      compared++; if (res !== 32'h8000_0000) begin mismatched++; $display("FAIL add_wrap got %h want 80000000", res); end
      compared++; if ({vx, vr} !== 2'b01) begin mismatched++; $display("FAIL latency got %b want 01", {vx, vr}); end
      do_op(0, 32'hFFFF_FFFF, 32'd1, CTL_SLTU, 0, rdy, vx, vr, rid, res, z, ill);
      compared++; if (res !== 32'd0) begin mismatched++; $display("FAIL sltu got %h want 0", res); end
      do_op(0, 32'hFFFF_FFFF, 32'd1, CTL_SLT, 0, rdy, vx, vr, rid, res, z, ill);
      compared++; if (res !== 32'd1) begin mismatched++; $display("FAIL slt got %h want 1", res); end
      do_op(0, 32'd0, 32'd1, CTL_SLL, 5'd31, rdy, vx, vr, rid, res, z, ill);
      compared++; if (res !== 32'h8000_0000) begin mismatched++; $display("FAIL sll31 got %h want 80000000", res); end
      do_op(0, 32'd0, 32'h8000_0000, CTL_SRL, 5'd4, rdy, vx, vr, rid, res, z, ill);
      compared++; if (res !== 32'h0800_0000) begin mismatched++; $display("FAIL srl4 got %h want 08000000", res); end
      do_op(0, 32'd9, 32'd9, CTL_SUB, 0, rdy, vx, vr, rid, res, z, ill);
      compared++; if ({res, z} !== {32'd0, 1'b1}) begin mismatched++; $display("FAIL sub_eq got %h/%b want 0/1", res, z); end
      do_op(0, 32'h0000_F0F0, 32'h0000_FF00, CTL_AND, 0, rdy, vx, vr, rid, res, z, ill);
      compared++; if (res !== 32'h0000_F000) begin mismatched++; $display("FAIL and got %h want 0000f000", res); end
      do_op(0, 32'h0000_F0F0, 32'h0000_FF00, CTL_OR, 0, rdy, vx, vr, rid, res, z, ill);
      compared++; if (res !== 32'h0000_FFF0) begin mismatched++; $display("FAIL or got %h want 0000fff0", res); end
      do_op(1, 32'd20, 32'd5, CTL_SUB, 0, rdy, vx, vr, rid, res, z, ill);
      compared++; if (rdy !== 2'b10) begin mismatched++; $display("FAIL lone1_ready got %b want 10", rdy); end
      compared++; if ({rid, res} !== {1'b1, 32'd15}) begin mismatched++; $display("FAIL lone1_resp got %b/%0d want 1/15", rid, res); end
   endtask

   task automatic test_illegal;
      logic [1:0] rdy; logic vx, vr, rid, z, ill; logic [31:0] res;
      do_op(0, 32'd3, 32'd4, 4'b0101, 0, rdy, vx, vr, rid, res, z, ill);
      compared++; if ({res, ill} !== {32'd0, 1'b1}) begin mismatched++; $display("FAIL illegal got %h/%b want 0/1", res, ill); end
      do_op(0, 32'd3, 32'd4, CTL_ADD, 0, rdy, vx, vr, rid, res, z, ill);
      compared++; if ({res, ill} !== {32'd7, 1'b0}) begin mismatched++; $display("FAIL legal_after got %h/%b want 7/0", res, ill); end
   endtask

   task automatic test_backpressure;
      @(negedge clk);
      set_req(0, 32'hFFFF_FFFF, 32'd1, CTL_SLT, 0);
      bus.reqValid = 2'b01;
      #1;
      compared++; if (bus.reqReady !== 2'b01) begin mismatched++; $display("FAIL bp_ready got %b want 01", bus.reqReady); end
      @(posedge clk); #1;
      bus.reqValid = 2'b11;
      set_req(0, 32'd100, 32'd1, CTL_SLT, 0);
      #1;
      compared++; if (bus.reqReady !== 2'b00) begin mismatched++; $display("FAIL bp_exec_ready got %b want 00", bus.reqReady); end
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         compared++; if ({bus.respValid, bus.respResult} !== {1'b1, 32'd1}) begin mismatched++; $display("FAIL bp_hold%0d got %b/%h want 1/1", i, bus.respValid, bus.respResult); end
         compared++; if (bus.reqReady !== 2'b00) begin mismatched++; $display("FAIL bp_ready%0d got %b want 00", i, bus.reqReady); end
         @(posedge clk); #1;
      end
      bus.reqValid  = 2'b00;
      bus.respReady = 1'b1;
      @(posedge clk); #1;
      bus.respReady = 1'b0;
      compared++; if (bus.respValid !== 1'b0) begin mismatched++; $display("FAIL bp_release got %b want 0", bus.respValid); end
      bus.reqValid = 2'b10;
      #1;
      compared++; if (bus.reqReady !== 2'b10) begin mismatched++; $display("FAIL bp_idle got %b want 10", bus.reqReady); end
      bus.reqValid = 2'b00;
   endtask

   task automatic test_contention;
      logic [1:0] exp;
      @(negedge clk);
      rst_n = 1'b0;
      bus.reqValid  = 2'b00;
      bus.respReady = 1'b0;
      #2 rst_n = 1'b1;
      set_req(0, 32'd1, 32'd2, CTL_ADD, 0);
      set_req(1, 32'd100, 32'd200, CTL_ADD, 0);
      bus.respReady = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         bus.reqValid = 2'b11;
         #1;
         exp = (k % 2 == 0) ? 2'b01 : 2'b10;
         compared++; if (bus.reqReady !== exp) begin mismatched++; $display("FAIL rr_grant%0d got %b want %b", k, bus.reqReady, exp); end
         compared++; if (bus_fp.reqReady !== 2'b01) begin mismatched++; $display("FAIL fp_grant%0d got %b want 01", k, bus_fp.reqReady); end
         @(posedge clk);
         @(posedge clk); #1;
         compared++; if ({bus.respValid, bus.respId} !== {1'b1, exp[1]}) begin mismatched++; $display("FAIL rr_resp%0d got %b/%b want 1/%b", k, bus.respValid, bus.respId, exp[1]); end
         compared++; if (bus.respResult !== (exp[1] ? 32'd300 : 32'd3)) begin mismatched++; $display("FAIL rr_result%0d got %0d", k, bus.respResult); end
         compared++; if ({bus_fp.respId, bus_fp.respResult} !== {1'b0, 32'd3}) begin mismatched++; $display("FAIL fp_resp%0d got %b/%0d want 0/3", k, bus_fp.respId, bus_fp.respResult); end
         compared++; if (bus.reqReady !== 2'b00) begin mismatched++; $display("FAIL rr_busy%0d got %b want 00", k, bus.reqReady); end
         @(posedge clk);
      end
      #1;
      bus.reqValid  = 2'b00;
      bus.respReady = 1'b0;
   endtask

   task automatic test_reset_mid;
      logic [1:0] rdy; logic vx, vr, rid, z, ill; logic [31:0] res;
      do_op(0, 32'd4, 32'd4, CTL_ADD, 0, rdy, vx, vr, rid, res, z, ill);
      @(negedge clk);
      set_req(0, 32'd6, 32'd6, CTL_ADD, 0);
      bus.reqValid = 2'b01;
      @(posedge clk); #1;
      bus.reqValid = 2'b11;
      rst_n = 1'b0;
      #1;
      compared++; if ({bus.respValid, bus.respResult} !== {1'b0, 32'd0}) begin mismatched++; $display("FAIL mid_rst_out got %b/%h want 0/0", bus.respValid, bus.respResult); end
      compared++; if (bus.reqReady !== 2'b00) begin mismatched++; $display("FAIL mid_rst_ready got %b want 00", bus.reqReady); end
      bus.reqValid = 2'b00;
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         compared++; if (bus.respValid !== 1'b0) begin mismatched++; $display("FAIL mid_rst_quiet%0d got %b want 0", i, bus.respValid); end
      end
      @(negedge clk);
      bus.reqValid = 2'b11;
      #1;
      compared++; if (bus.reqReady !== 2'b01) begin mismatched++; $display("FAIL mid_rst_winner got %b want 01", bus.reqReady); end
      bus.reqValid = 2'b00;
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_boundaries();
      test_illegal();
      test_backpressure();
      test_contention();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
